// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator family.
//   cmp_state_e  : IDLE / RUN / DONE sequencing state
//   CMP_DIG_W    : width of one comparator digit (bits)
//   is_one_hot3  : true when an {eq,lt,gt} flag triple has exactly one bit set
package cmp_pkg;

  localparam int CMP_DIG_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  function automatic logic is_one_hot3(input logic eq, input logic lt, input logic gt);
    logic [2:0] w_flags;
    w_flags = {eq, lt, gt};
    return (w_flags == 3'b100) || (w_flags == 3'b010) || (w_flags == 3'b001);
  endfunction

endpackage

// File: rtl/digit_serial_cmp_seq.sv
// Sequential magnitude resolver for digit-serial compares.
// Consumes per-digit eq/lt/gt flags (MSB digit first) from a 2-bit comparator
// and resolves the multi-digit verdict. The first non-equal digit decides; later
// digits are still consumed so the upstream stays digit-aligned.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start                      begin a compare (sampled in IDLE only)
//   dig_valid, dig_ready       per-digit handshake
//   dig_eq, dig_lt, dig_gt     upstream digit flags
//   busy                       compare in progress (RUN or DONE)
//   done                       one-cycle result-valid pulse
//   res_eq, res_lt, res_gt     final verdict, held until next start
//   err                        sticky: a non-one-hot digit was accepted
module digit_serial_cmp_seq
  import cmp_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic dig_valid,
  input  logic dig_eq,
  input  logic dig_lt,
  input  logic dig_gt,
  output logic dig_ready,
  output logic busy,
  output logic done,
  output logic res_eq,
  output logic res_lt,
  output logic res_gt,
  output logic err
);

  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  cmp_state_e       r_state;
  cmp_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_decided;
  logic             r_dir_lt;
  logic             r_dir_gt;
  logic             r_res_eq;
  logic             r_res_lt;
  logic             r_res_gt;
  logic             r_err;

  logic w_accept;
  logic w_well_formed;
  logic w_last;
  logic w_take;
  logic w_fin_lt;
  logic w_fin_gt;

  assign dig_ready = (r_state == RUN);
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign res_eq    = r_res_eq;
  assign res_lt    = r_res_lt;
  assign res_gt    = r_res_gt;
  assign err       = r_err;

  assign w_accept      = dig_ready & dig_valid;
  assign w_well_formed = is_one_hot3(dig_eq, dig_lt, dig_gt);
  assign w_last        = (r_cnt == LAST_CNT);

  // A malformed digit counts as equal, so it can never decide the verdict.
  assign w_take   = ~r_decided & w_well_formed & (dig_lt | dig_gt);

  // Verdict including the digit being accepted now (the last digit may decide).
  assign w_fin_lt = r_decided ? r_dir_lt : (w_take & dig_lt);
  assign w_fin_gt = r_decided ? r_dir_gt : (w_take & dig_gt);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: next state is defaulted first so no path through the case leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_accept && w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_decided <= 1'b0;
      r_dir_lt  <= 1'b0;
      r_dir_gt  <= 1'b0;
      r_res_eq  <= 1'b0;
      r_res_lt  <= 1'b0;
      r_res_gt  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt     <= '0;
            r_decided <= 1'b0;
            r_dir_lt  <= 1'b0;
            r_dir_gt  <= 1'b0;
            r_res_eq  <= 1'b0;
            r_res_lt  <= 1'b0;
            r_res_gt  <= 1'b0;
            r_err     <= 1'b0;
          end
        end
        RUN: begin
          if (w_accept) begin
            if (!w_well_formed) r_err <= 1'b1;
            if (w_take) begin
              r_decided <= 1'b1;
              r_dir_lt  <= dig_lt;
              r_dir_gt  <= dig_gt;
            end
            if (w_last) begin
              r_res_lt <= w_fin_lt;
              r_res_gt <= w_fin_gt;
              r_res_eq <= ~(w_fin_lt | w_fin_gt);
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_cmp_seq.sv
// Directed bench for digit_serial_cmp_seq: a 4-digit instance and a 1-digit
// instance share clock and reset. Observed outputs are packed as
// {dig_ready, busy, done, res_eq, res_lt, res_gt, err}.
module tb_digit_serial_cmp_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic start, dig_valid, dig_eq, dig_lt, dig_gt;
  logic dig_ready, busy, done, res_eq, res_lt, res_gt, err;

  logic start1, dig_valid1, dig_eq1, dig_lt1, dig_gt1;
  logic dig_ready1, busy1, done1, res_eq1, res_lt1, res_gt1, err1;

  logic [6:0] obs, obs1;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [6:0] O_ZERO    = 7'b0000000;
  localparam logic [6:0] O_RUN     = 7'b1100000;
  localparam logic [6:0] O_RUN_ERR = 7'b1100001;
  localparam logic [6:0] O_DONE_EQ = 7'b0111000;
  localparam logic [6:0] O_DONE_LT = 7'b0110100;
  localparam logic [6:0] O_DONE_GT = 7'b0110010;
  localparam logic [6:0] O_DLT_ERR = 7'b0110101;
  localparam logic [6:0] O_HOLD_EQ = 7'b0001000;
  localparam logic [6:0] O_HOLD_LT = 7'b0000100;
  localparam logic [6:0] O_HOLD_GT = 7'b0000010;
  localparam logic [6:0] O_HLT_ERR = 7'b0000101;

  digit_serial_cmp_seq #(.NUM_DIGITS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dig_valid(dig_valid),
    .dig_eq(dig_eq), .dig_lt(dig_lt), .dig_gt(dig_gt),
    .dig_ready(dig_ready), .busy(busy), .done(done),
    .res_eq(res_eq), .res_lt(res_lt), .res_gt(res_gt), .err(err)
  );

  digit_serial_cmp_seq #(.NUM_DIGITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dig_valid(dig_valid1),
    .dig_eq(dig_eq1), .dig_lt(dig_lt1), .dig_gt(dig_gt1),
    .dig_ready(dig_ready1), .busy(busy1), .done(done1),
    .res_eq(res_eq1), .res_lt(res_lt1), .res_gt(res_gt1), .err(err1)
  );

  assign obs  = {dig_ready, busy, done, res_eq, res_lt, res_gt, err};
  assign obs1 = {dig_ready1, busy1, done1, res_eq1, res_lt1, res_gt1, err1};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] observed, input logic [6:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dig(input logic v, input logic eq, input logic lt, input logic gt);
    dig_valid = v;
    dig_eq    = eq;
    dig_lt    = lt;
    dig_gt    = gt;
  endtask

  initial begin
    start = 1'b0; set_dig(1'b0, 1'b0, 1'b0, 1'b0);
    start1 = 1'b0; dig_valid1 = 1'b0; dig_eq1 = 1'b0; dig_lt1 = 1'b0; dig_gt1 = 1'b0;

    // Reset state
    #12;
    check("reset_n4", obs, O_ZERO);
    check("reset_n1", obs1, O_ZERO);
    #1 rst_n = 1'b1;
    tick();
    check("idle_after_reset", obs, O_ZERO);

    // 1: B4 vs B1 -> digits eq, eq, gt, lt back-to-back -> gt
    start = 1'b1;
    tick();                                 // E0
    start = 1'b0; set_dig(1'b1, 1'b1, 1'b0, 1'b0);
    check("t1_run_entry", obs, O_RUN);
    tick();                                 // E1: eq
    tick();                                 // E2: eq
    set_dig(1'b1, 1'b0, 1'b0, 1'b1);
    tick();                                 // E3: gt
    set_dig(1'b1, 1'b0, 1'b1, 1'b0);
    check("t1_no_early_done", obs, O_RUN);
    tick();                                 // E4: lt, last beat
    set_dig(1'b0, 1'b0, 1'b0, 1'b0);
    check("t1_done_gt", obs, O_DONE_GT);
    tick();
    check("t1_hold_gt", obs, O_HOLD_GT);

    // 2: 5A vs 5A, eq digits with valid low on alternating cycles -> eq
    start = 1'b1;
    tick();                                 // E0
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_dig(1'b1, 1'b1, 1'b0, 1'b0);
      tick();                               // beat accepted
      set_dig(1'b0, 1'b0, 1'b0, 1'b0);
      if (i < 3) begin
        check("t2_run_after_beat", obs, O_RUN);
        tick();                             // stall cycle
        check("t2_run_stall", obs, O_RUN);
      end else begin
        check("t2_done_eq", obs, O_DONE_EQ);
      end
    end
    tick();
    check("t2_hold_eq", obs, O_HOLD_EQ);

    // 3: eq, malformed (lt&gt), eq, lt -> err=1, res_lt=1
    start = 1'b1;
    tick();
    start = 1'b0; set_dig(1'b1, 1'b1, 1'b0, 1'b0);
    tick();                                 // eq
    set_dig(1'b1, 1'b0, 1'b1, 1'b1);
    tick();                                 // malformed
    set_dig(1'b1, 1'b1, 1'b0, 1'b0);
    check("t3_err_sticky_run", obs, O_RUN_ERR);
    tick();                                 // eq
    set_dig(1'b1, 1'b0, 1'b1, 1'b0);
    tick();                                 // lt, last
    set_dig(1'b0, 1'b0, 1'b0, 1'b0);
    check("t3_done_lt_err", obs, O_DLT_ERR);
    tick();
    check("t3_hold_lt_err", obs, O_HLT_ERR);

    // 4: start re-pulsed mid-RUN is ignored; eq, eq, gt, eq -> gt (also checks err cleared)
    start = 1'b1;
    tick();
    start = 1'b0; set_dig(1'b1, 1'b1, 1'b0, 1'b0);
    check("t4_start_clears_err", obs, O_RUN);
    tick();                                 // eq
    tick();                                 // eq
    start = 1'b1; set_dig(1'b1, 1'b0, 1'b0, 1'b1);
    tick();                                 // gt, start ignored
    start = 1'b0; set_dig(1'b1, 1'b1, 1'b0, 1'b0);
    check("t4_run_after_restart", obs, O_RUN);
    tick();                                 // eq, last
    set_dig(1'b0, 1'b0, 1'b0, 1'b0);
    check("t4_done_gt", obs, O_DONE_GT);
    tick();
    check("t4_single_done", obs, O_HOLD_GT);
    tick();
    check("t4_stays_idle", obs, O_HOLD_GT);

    // 5: reset after 3 accepted digits, then a clean compare
    start = 1'b1;
    tick();
    start = 1'b0; set_dig(1'b1, 1'b0, 1'b1, 1'b0);
    tick();                                 // lt
    set_dig(1'b1, 1'b1, 1'b0, 1'b0);
    tick();                                 // eq
    tick();                                 // eq (3 accepted)
    set_dig(1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_reset", obs, O_ZERO);
    tick();
    check("t5_in_reset", obs, O_ZERO);
    #2 rst_n = 1'b1;
    tick();
    check("t5_no_done_after_reset", obs, O_ZERO);
    // start with a digit also valid in IDLE: that digit must not be taken
    start = 1'b1; set_dig(1'b1, 1'b0, 1'b1, 1'b0);
    tick();                                 // E0
    start = 1'b0; set_dig(1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_restart_run", obs, O_RUN);
    tick();                                 // eq
    tick();                                 // eq
    tick();                                 // eq
    set_dig(1'b1, 1'b0, 1'b0, 1'b1);
    check("t5_no_early_done", obs, O_RUN);
    tick();                                 // gt, last
    set_dig(1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_done_gt", obs, O_DONE_GT);

    // 6: NUM_DIGITS=1, single lt digit
    start1 = 1'b1;
    tick();
    start1 = 1'b0; dig_valid1 = 1'b1; dig_lt1 = 1'b1;
    check("t6_run", obs1, O_RUN);
    tick();
    dig_valid1 = 1'b0; dig_lt1 = 1'b0;
    check("t6_done_lt", obs1, O_DONE_LT);
    tick();
    check("t6_hold_lt", obs1, O_HOLD_LT);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/digit_serial_cmp_seq.md
# digit_serial_cmp_seq

Sequential magnitude resolver that sits directly downstream of the 2-bit comparator. Operands of width 2·NUM_DIGITS are presented MSB digit first, one digit pair per beat, to the 2-bit comparator. This block consumes the comparator's per-digit equal/less/greater flags under a valid/ready handshake. It produces the final multi-digit A==B / A<B / A>B verdict with a one-cycle done pulse and a sticky error flag for malformed flags.

## Interface
Parameters:
- NUM_DIGITS, default 4: number of 2-bit digits per compare (4 → 8-bit operands); legal range 1..16.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a compare; sampled only in IDLE.
- dig_valid  in  1  digit flags valid this cycle.
- dig_eq  in  1  upstream digit A==B.
- dig_lt  in  1  upstream digit A<B.
- dig_gt  in  1  upstream digit A>B.
- dig_ready  out  1  block accepts a digit this cycle.
- busy  out  1  compare in progress (RUN or DONE).
- done  out  1  one-cycle pulse; result valid.
- res_eq  out  1  final A==B.
- res_lt  out  1  final A<B.
- res_gt  out  1  final A>B.
- err  out  1  a non-one-hot digit was accepted during this compare.

One clock; reset is asynchronous and active-low.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on start=1. On this transition:
  - digit counter cleared.
  - decided flag cleared.
  - res_* and err cleared.
- RUN:
  - dig_ready=1.
  - A beat is accepted when dig_valid & dig_ready.
  - For each accepted beat, if decided=0 and the digit is lt or gt: latch that direction and set decided=1.
  - Digits after a decision are consumed but ignored. No early exit, so the upstream stays digit-aligned.
- Last beat (counter == NUM_DIGITS-1):
  - Transition to DONE.
  - res_* registered: the latched direction, or res_eq=1 if never decided.
- DONE: lasts one cycle with done=1 and dig_ready=0, then returns to IDLE.
- res_* and err hold their values until the next accepted start.
- Flag check: a digit is well-formed only if {dig_eq,dig_lt,dig_gt} is exactly one-hot.
  - A malformed digit sets err, which is sticky until the next start.
  - A malformed digit is treated as equal for the verdict.
- Exactly one res_* bit is high after done. All are 0 between start and done, and after reset.
- Counter width: max(1, $clog2(NUM_DIGITS)). The counter never wraps inside a compare.

## Timing
- Reset values: state=IDLE, dig_ready=0, busy=0, done=0, res_eq=res_lt=res_gt=0, err=0, counter=0, decided=0.
- Asserting rst_n low mid-compare returns to IDLE immediately. No done pulse; the partial result is discarded.
- start is sampled at edge E0. From the cycle after E0: busy=1, dig_ready=1.
- One digit per cycle at full rate. Cycles with dig_valid=0 stall without state change.
- Last beat accepted at edge Ek. In the following cycle, done=1 and res_* are valid.
- At the next edge the block returns to IDLE (busy=0).
- Minimum start-to-done latency: NUM_DIGITS+1 cycles after the start edge.
- start while RUN or DONE is ignored. The earliest new start is sampled in the cycle after done.
- start and a dig_valid in IDLE in the same cycle: the digit is not accepted, because dig_ready=0.
- dig_valid while not ready: ignored. The upstream must hold the digit.

## Structure
- Shared package cmp_pkg:
  - state typedef (enum IDLE/RUN/DONE).
  - CMP_DIG_W=2 digit-width constant.
  - one-hot check function for the eq/lt/gt triple, reused by other comparator-family blocks.
- Single module; no sub-module is natural. The 2-bit comparator is instantiated by the parent alongside, not inside this block.

## Test plan
- NUM_DIGITS=4, A=8'hB4, B=8'hB1; flags stream eq, eq, gt, lt back-to-back → done at start+5 cycles, res_gt=1, res_lt=0, res_eq=0, err=0.
- A=B=8'h5A; four eq digits with dig_valid low on alternating cycles → res_eq=1, done 8 cycles after the first beat, dig_ready held high throughout RUN.
- Second digit driven with dig_lt=dig_gt=1, remaining digits eq, eq, lt → err=1, res_lt=1. The following start clears err to 0.
- start pulsed again during RUN after 2 digits → ignored. The compare finishes with exactly 4 accepted beats and a single done pulse.
- rst_n low for one cycle after 3 accepted digits → all outputs 0 immediately, no done. A new compare then runs correctly from digit 0.
- NUM_DIGITS=1: start, then one lt digit → done in the cycle after acceptance, res_lt=1.
